// File: rtl/fetch_prefetcher_pkg.sv
// Shared constants for the instruction prefetch unit.
//   DEPTH_LOG2_DEFAULT : default log2 of the prefetch FIFO depth (4 entries)
//   RESET_ADDR_DEFAULT : Z8 reset vector, first fetch address after reset
//   MEM_READ_LATENCY   : cycles from memStrobe to valid memDataIn
package fetch_prefetcher_pkg;

  localparam int unsigned DEPTH_LOG2_DEFAULT = 2;
  localparam logic [15:0] RESET_ADDR_DEFAULT = 16'h000C;
  localparam int unsigned MEM_READ_LATENCY   = 1;

endpackage

// File: rtl/fetch_prefetcher_if.sv
// Bus bundle between the prefetcher, the program memory and the CPU decoder.
//   memAddr/memStrobe/memDataIn : program memory read port
//   stall                       : CPU owns the memory port this cycle
//   jump/jumpAddr               : flush and redirect request
//   fetchByte/fetchAddr/fetchValid/fetchReady : byte stream to the decoder
// master = prefetcher side, slave = memory/CPU side.
interface fetch_prefetcher_if #(
  parameter int unsigned addrWidth = 16
);

  logic [addrWidth-1:0] memAddr;
  logic                 memStrobe;
  logic [7:0]           memDataIn;
  logic                 stall;
  logic                 jump;
  logic [addrWidth-1:0] jumpAddr;
  logic [7:0]           fetchByte;
  logic [addrWidth-1:0] fetchAddr;
  logic                 fetchValid;
  logic                 fetchReady;

  modport master (
    output memAddr, memStrobe, fetchByte, fetchAddr, fetchValid,
    input  memDataIn, stall, jump, jumpAddr, fetchReady
  );

  modport slave (
    input  memAddr, memStrobe, fetchByte, fetchAddr, fetchValid,
    output memDataIn, stall, jump, jumpAddr, fetchReady
  );

endinterface

// File: rtl/fetch_prefetcher_fifo.sv
// Byte FIFO holding prefetched instruction bytes.
//   clk, resetN : clock and synchronous active-low reset
//   flush       : empty the FIFO (takes priority over push/pop)
//   push        : write push_data at the tail
//   pop         : drop the head entry
//   head_data   : head entry, forced to zero while empty
//   count       : number of stored entries, 0..2^depthLog2
// The caller guarantees no push when full and no pop when empty.
module fetch_prefetcher_fifo
  import fetch_prefetcher_pkg::*;
#(
  parameter int unsigned depthLog2 = DEPTH_LOG2_DEFAULT
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 flush,
  input  logic                 push,
  input  logic                 pop,
  input  logic [7:0]           push_data,
  output logic [7:0]           head_data,
  output logic [depthLog2:0]   count
);

  localparam int unsigned DEPTH = 1 << depthLog2;

  logic [7:0]           storage [DEPTH];
  logic [depthLog2-1:0] wr_ptr;
  logic [depthLog2-1:0] rd_ptr;
  logic [depthLog2:0]   count_q;

  always_ff @(posedge clk) begin
    if (!resetN || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is data only; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push && !flush) storage[wr_ptr] <= push_data;
  end

  assign head_data = (count_q != '0) ? storage[rd_ptr] : 8'h00;
  assign count     = count_q;

endmodule

// File: rtl/fetch_prefetcher.sv
// Instruction prefetch unit in front of the program memory.
//   clk    : clock, all state on rising edge
//   resetN : synchronous active-low reset
//   bus    : fetch_prefetcher_if.master carrying the memory read port,
//            stall, jump/jumpAddr and the fetch byte handshake
// Reads bytes sequentially from fetch_pc, captures the registered memory
// data one cycle after each strobe and queues it for the decoder. A FIFO
// slot is reserved at issue time, so captures can never overflow.
module fetch_prefetcher
  import fetch_prefetcher_pkg::*;
#(
  parameter int unsigned          addrWidth = 16,
  parameter int unsigned          depthLog2 = DEPTH_LOG2_DEFAULT,
  parameter logic [addrWidth-1:0] resetAddr = addrWidth'(RESET_ADDR_DEFAULT)
) (
  input  logic              clk,
  input  logic              resetN,
  fetch_prefetcher_if.master bus
);

  localparam int unsigned DEPTH = 1 << depthLog2;

  logic [addrWidth-1:0]        fetch_pc;
  logic [addrWidth-1:0]        head_addr;
  logic [MEM_READ_LATENCY-1:0] inflight;
  logic [depthLog2:0]          count;
  logic [7:0]                  head_data;
  logic                        has_room;
  logic                        issue;
  logic                        capture;
  logic                        pop;

  always_comb begin
    // Outstanding reads already own a slot.
    has_room = (int'(count) + $countones(inflight)) < int'(DEPTH);
    issue    = resetN & ~bus.jump & ~bus.stall & has_room;
    // The memory only holds its data until the next strobe, so the byte
    // is taken exactly when it emerges, stall or not.
    capture  = inflight[MEM_READ_LATENCY-1] & ~bus.jump;
    pop      = (count != '0) & bus.fetchReady & ~bus.jump;
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      fetch_pc  <= resetAddr;
      head_addr <= resetAddr;
      inflight  <= '0;
    end else if (bus.jump) begin
      fetch_pc  <= bus.jumpAddr;
      head_addr <= bus.jumpAddr;
      inflight  <= '0;
    end else begin
      inflight <= MEM_READ_LATENCY'({inflight, issue});
      if (issue) fetch_pc  <= fetch_pc + 1'b1;
      if (pop)   head_addr <= head_addr + 1'b1;
    end
  end

  fetch_prefetcher_fifo #(
    .depthLog2 (depthLog2)
  ) u_fifo (
    .clk       (clk),
    .resetN    (resetN),
    .flush     (bus.jump),
    .push      (capture),
    .pop       (pop),
    .push_data (bus.memDataIn),
    .head_data (head_data),
    .count     (count)
  );

  assign bus.memAddr    = fetch_pc;
  assign bus.memStrobe  = issue;
  assign bus.fetchByte  = head_data;
  assign bus.fetchAddr  = head_addr;
  assign bus.fetchValid = (count != '0);

endmodule

// File: tb/tb_fetch_prefetcher.sv
module tb_fetch_prefetcher;

  logic clk = 1'b0;
  logic resetN;

  always #5 clk = ~clk;

  fetch_prefetcher_if #(.addrWidth(16)) bus();

  fetch_prefetcher #(
    .addrWidth (16),
    .depthLog2 (2),
    .resetAddr (16'h000C)
  ) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  // Program memory: registers the addressed byte on each strobe.
  logic [7:0] mem [0:65535];
  always @(posedge clk) if (bus.memStrobe) bus.memDataIn <= mem[bus.memAddr];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } entry_t;

  entry_t      sb_q[$];
  bit          mon_en = 1'b0;
  bit          inf_m  = 1'b0;
  bit          exp_strobe;
  logic [15:0] inf_addr_m;
  logic [15:0] pc_m;

  always @(negedge clk) begin
    if (!resetN) begin
      check("sb_strobe_in_reset", 32'(bus.memStrobe), 32'd0);
      sb_q.delete();
      inf_m  = 1'b0;
      pc_m   = 16'h000C;
      mon_en = 1'b1;
    end else if (mon_en) begin
      exp_strobe = !bus.jump && !bus.stall && ((sb_q.size() + int'(inf_m)) < 4);
      check("sb_strobe", 32'(bus.memStrobe), 32'(exp_strobe));
      if (exp_strobe) check("sb_mem_addr", 32'(bus.memAddr), 32'(pc_m));
      check("sb_valid", 32'(bus.fetchValid), 32'(sb_q.size() != 0));
      if (sb_q.size() != 0) begin
        check("sb_fetch_addr", 32'(bus.fetchAddr), 32'(sb_q[0].addr));
        check("sb_fetch_byte", 32'(bus.fetchByte), 32'(sb_q[0].data));
      end
      if (bus.jump) begin
        sb_q.delete();
        inf_m = 1'b0;
        pc_m  = bus.jumpAddr;
      end else begin
        if (sb_q.size() != 0 && bus.fetchReady) void'(sb_q.pop_front());
        if (inf_m) sb_q.push_back('{addr: inf_addr_m, data: mem[inf_addr_m]});
        inf_m = exp_strobe;
        if (exp_strobe) begin
          inf_addr_m = pc_m;
          pc_m       = pc_m + 16'd1;
        end
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst_n;
    logic        stall;
    logic        jump;
    logic [15:0] jaddr;
    logic        ready;
    logic        chk_maddr;
    logic        chk_fetch;
    logic        e_strobe;
    logic [15:0] e_maddr;
    logic        e_valid;
    logic [7:0]  e_byte;
    logic [15:0] e_faddr;
  } vec_t;

  vec_t vt [19];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic s, input logic j,
                       input logic [15:0] ja, input logic rd);
    resetN       = r;
    bus.stall    = s;
    bus.jump     = j;
    bus.jumpAddr = ja;
    bus.fetchReady = rd;
  endtask

  logic [15:0] got_addr [3];
  logic [7:0]  got_byte [3];
  int          n_got;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < 65536; a++) begin
      logic [15:0] av;
      av = 16'(a);
      mem[a] = av[7:0] ^ av[15:8] ^ 8'h5A;
    end
    mem[16'h000C] = 8'hA1;
    mem[16'h000D] = 8'hB2;

    drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    bus.memDataIn = 8'h00;

    //       rst stl jmp jaddr     rdy  cM cF  stb  maddr     vld byte   faddr
    vt[0]  = '{1, 0, 0, 16'h0000, 1,  1, 1,  1, 16'h000C, 0, 8'h00, 16'h000C};
    vt[1]  = '{1, 0, 0, 16'h0000, 1,  1, 1,  1, 16'h000D, 0, 8'h00, 16'h000C};
    vt[2]  = '{1, 0, 0, 16'h0000, 1,  1, 1,  1, 16'h000E, 1, 8'hA1, 16'h000C};
    vt[3]  = '{1, 0, 0, 16'h0000, 1,  1, 1,  1, 16'h000F, 1, 8'hB2, 16'h000D};
    vt[4]  = '{1, 0, 1, 16'h0200, 1,  1, 1,  0, 16'h0010, 1, 8'h54, 16'h000E};
    vt[5]  = '{1, 0, 0, 16'h0000, 1,  1, 1,  1, 16'h0200, 0, 8'h00, 16'h0200};
    vt[6]  = '{1, 0, 0, 16'h0000, 1,  1, 1,  1, 16'h0201, 0, 8'h00, 16'h0200};
    vt[7]  = '{1, 0, 0, 16'h0000, 1,  1, 1,  1, 16'h0202, 1, 8'h58, 16'h0200};
    vt[8]  = '{0, 0, 0, 16'h0000, 0,  0, 0,  0, 16'h0000, 0, 8'h00, 16'h0000};
    vt[9]  = '{1, 0, 0, 16'h0000, 0,  1, 1,  1, 16'h000C, 0, 8'h00, 16'h000C};
    vt[10] = '{1, 0, 0, 16'h0000, 0,  1, 1,  1, 16'h000D, 0, 8'h00, 16'h000C};
    vt[11] = '{1, 0, 0, 16'h0000, 0,  1, 1,  1, 16'h000E, 1, 8'hA1, 16'h000C};
    vt[12] = '{1, 0, 0, 16'h0000, 0,  1, 1,  1, 16'h000F, 1, 8'hA1, 16'h000C};
    vt[13] = '{1, 0, 0, 16'h0000, 0,  1, 1,  0, 16'h0010, 1, 8'hA1, 16'h000C};
    vt[14] = '{1, 0, 0, 16'h0000, 0,  1, 1,  0, 16'h0010, 1, 8'hA1, 16'h000C};
    vt[15] = '{1, 0, 0, 16'h0000, 0,  1, 1,  0, 16'h0010, 1, 8'hA1, 16'h000C};
    vt[16] = '{1, 0, 0, 16'h0000, 1,  1, 1,  0, 16'h0010, 1, 8'hA1, 16'h000C};
    vt[17] = '{1, 0, 0, 16'h0000, 0,  1, 1,  1, 16'h0010, 1, 8'hB2, 16'h000D};
    vt[18] = '{1, 0, 0, 16'h0000, 0,  1, 1,  0, 16'h0011, 1, 8'hB2, 16'h000D};

    step();
    step();

    for (int i = 0; i < 19; i++) begin
      drive(vt[i].rst_n, vt[i].stall, vt[i].jump, vt[i].jaddr, vt[i].ready);
      @(negedge clk);
      check($sformatf("vec%0d_strobe", i), 32'(bus.memStrobe), 32'(vt[i].e_strobe));
      if (vt[i].chk_maddr)
        check($sformatf("vec%0d_mem_addr", i), 32'(bus.memAddr), 32'(vt[i].e_maddr));
      if (vt[i].chk_fetch) begin
        check($sformatf("vec%0d_valid", i), 32'(bus.fetchValid), 32'(vt[i].e_valid));
        check($sformatf("vec%0d_byte", i), 32'(bus.fetchByte), 32'(vt[i].e_byte));
        check($sformatf("vec%0d_faddr", i), 32'(bus.fetchAddr), 32'(vt[i].e_faddr));
      end
      step();
    end

    // Stall for three cycles with one read outstanding.
    drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    step();
    drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    @(negedge clk);
    check("stall_pre_strobe", 32'(bus.memStrobe), 32'd1);
    check("stall_pre_addr", 32'(bus.memAddr), 32'h000C);
    step();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
      @(negedge clk);
      check($sformatf("stall%0d_no_strobe", k), 32'(bus.memStrobe), 32'd0);
      step();
    end
    drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    @(negedge clk);
    check("stall_resume_strobe", 32'(bus.memStrobe), 32'd1);
    check("stall_resume_addr", 32'(bus.memAddr), 32'h000D);
    check("stall_captured_valid", 32'(bus.fetchValid), 32'd1);
    check("stall_captured_byte", 32'(bus.fetchByte), 32'hA1);
    check("stall_captured_faddr", 32'(bus.fetchAddr), 32'h000C);
    step();

    // Address wrap across 0xFFFF.
    drive(1'b1, 1'b0, 1'b1, 16'hFFFE, 1'b1);
    step();
    drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
    n_got = 0;
    for (int c = 0; c < 12 && n_got < 3; c++) begin
      @(negedge clk);
      if (bus.fetchValid) begin
        got_addr[n_got] = bus.fetchAddr;
        got_byte[n_got] = bus.fetchByte;
        n_got++;
      end
      step();
    end
    check("wrap_pop_count", 32'(n_got), 32'd3);
    if (n_got == 3) begin
      check("wrap_addr0", 32'(got_addr[0]), 32'hFFFE);
      check("wrap_byte0", 32'(got_byte[0]), 32'h5B);
      check("wrap_addr1", 32'(got_addr[1]), 32'hFFFF);
      check("wrap_byte1", 32'(got_byte[1]), 32'h5A);
      check("wrap_addr2", 32'(got_addr[2]), 32'h0000);
      check("wrap_byte2", 32'(got_byte[2]), 32'h5A);
    end

    // Reset while three bytes are queued and one read is outstanding.
    drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    step();
    drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    for (int k = 0; k < 4; k++) step();
    drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    @(negedge clk);
    check("midrst_pre_valid", 32'(bus.fetchValid), 32'd1);
    step();
    drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    @(negedge clk);
    check("midrst_valid", 32'(bus.fetchValid), 32'd0);
    check("midrst_byte", 32'(bus.fetchByte), 32'd0);
    check("midrst_mem_addr", 32'(bus.memAddr), 32'h000C);
    check("midrst_strobe", 32'(bus.memStrobe), 32'd1);
    step();
    @(negedge clk);
    check("midrst_valid_c1", 32'(bus.fetchValid), 32'd0);
    step();
    @(negedge clk);
    check("midrst_valid_c2", 32'(bus.fetchValid), 32'd1);
    check("midrst_byte_c2", 32'(bus.fetchByte), 32'hA1);
    check("midrst_faddr_c2", 32'(bus.fetchAddr), 32'h000C);
    step();

    // Random traffic; the scoreboard checks every cycle.
    for (int c = 0; c < 400; c++) begin
      drive(($urandom_range(0, 49) != 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 19) == 0),
            16'($urandom_range(0, 65535)),
            ($urandom_range(0, 2) != 0));
      step();
    end

    drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
    for (int c = 0; c < 10; c++) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
